// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the multiplier front end:
// rounding modes, constants, FSM states and operand classes.
package fpu_pkg;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;

    localparam int          FP32_BIAS  = 127;
    localparam logic [31:0] CANON_NAN  = 32'h7FC00000;
    localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;
    localparam logic [30:0] INF_MAG    = 31'h7F800000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_e;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } fp_cls_t;

    // Subnormals collapse to zero; quiet bit is frac[22].
    function automatic fp_cls_t classify(input logic [31:0] x);
        fp_cls_t c;
        logic    e_max;
        logic    f_nz;
        e_max  = (x[30:23] == 8'hFF);
        f_nz   = (x[22:0] != 23'd0);
        c.zero = (x[30:23] == 8'h00);
        c.inf  = e_max && !f_nz;
        c.nan  = e_max && f_nz;
        c.snan = e_max && f_nz && !x[22];
        return c;
    endfunction

    // Overflow result: inf or max finite depending on direction.
    function automatic logic [31:0] ovf_value(
        input logic       s,
        input logic [2:0] r
    );
        logic [30:0] mag;
        case (r)
            RTZ:     mag = MAX_FINITE;
            RDN:     mag = s ? INF_MAG : MAX_FINITE;
            RUP:     mag = s ? MAX_FINITE : INF_MAG;
            default: mag = INF_MAG;
        endcase
        return {s, mag};
    endfunction

endpackage

// File: rtl/fpu_mul_special.sv
// Combinational operand classifier for the FP32 multiplier.
// Produces per-operand classes and the bypass result.
module fpu_mul_special
    import fpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output fp_cls_t     cls_a_o,
    output fp_cls_t     cls_b_o,
    output logic [31:0] special_value_o,
    output logic        invalid_o
);

    logic s;

    assign cls_a_o = classify(a_i);
    assign cls_b_o = classify(b_i);
    assign s       = a_i[31] ^ b_i[31];

    // Prioritised special-result selection.
    always_comb begin
        special_value_o = '0;
        invalid_o       = 1'b0;
        if (cls_a_o.snan || cls_b_o.snan ||
            (cls_a_o.inf && cls_b_o.zero) ||
            (cls_a_o.zero && cls_b_o.inf)) begin
            special_value_o = CANON_NAN;
            invalid_o       = 1'b1;
        end else if (cls_a_o.nan || cls_b_o.nan) begin
            special_value_o = CANON_NAN;
        end else if (cls_a_o.inf || cls_b_o.inf) begin
            special_value_o = {s, INF_MAG};
        end else if (cls_a_o.zero || cls_b_o.zero) begin
            special_value_o = {s, 31'd0};
        end
    end

endmodule

// File: rtl/fpu_mul_core.sv
// Iterative shift-add FP32 multiplier feeding fpu_rounder.
// Special operands and exponent range faults bypass the rounder.
module fpu_mul_core
    import fpu_pkg::*;
#(
    parameter int BIAS = FP32_BIAS,
    parameter int ITER = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_mantissa,
    output logic [8:0]  out_exponent,
    output logic        out_sign,
    output logic        out_guard,
    output logic        out_round,
    output logic        out_sticky,
    output logic [2:0]  out_rm,
    output logic        out_special,
    output logic [31:0] out_special_value,
    output logic        out_invalid,
    output logic        out_overflow,
    output logic        out_underflow
);

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [2:0]         rm_q, rm_d;
    logic [23:0]        mcand_q, mcand_d;
    logic [23:0]        mplier_q, mplier_d;
    logic [47:0]        acc_q, acc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [47:0]        mant_q, mant_d;
    logic [8:0]         oexp_q, oexp_d;
    logic [2:0]         grs_q, grs_d;
    logic               spc_q, spc_d;
    logic [31:0]        sval_q, sval_d;
    logic               inv_q, inv_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    fp_cls_t            cls_a, cls_b;
    logic [31:0]        sp_value;
    logic               sp_inv;
    logic               is_spc;
    logic               sign;
    logic signed [9:0]  e_n;
    logic [47:0]        m_n;

    fpu_mul_special u_special (
        .a_i             (a_q),
        .b_i             (b_q),
        .cls_a_o         (cls_a),
        .cls_b_o         (cls_b),
        .special_value_o (sp_value),
        .invalid_o       (sp_inv)
    );

    assign is_spc = (|cls_a) || (|cls_b);
    assign sign   = a_q[31] ^ b_q[31];
    assign e_n    = acc_q[47] ? exp_q + 10'sd1 : exp_q;
    assign m_n    = acc_q[47] ? acc_q : {acc_q[46:0], 1'b0};

    // Next-state and datapath update for the four-state sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rm_d     = rm_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        oexp_d   = oexp_q;
        grs_d    = grs_q;
        spc_d    = spc_q;
        sval_d   = sval_q;
        inv_d    = inv_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    rm_d     = rm;
                    mcand_d  = {1'b1, a[22:0]};
                    mplier_d = {1'b1, b[22:0]};
                    acc_d    = '0;
                    cnt_d    = '0;
                    exp_d    = {2'b00, a[30:23]}
                             + {2'b00, b[30:23]}
                             - 10'(BIAS);
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (is_spc) begin
                    mant_d  = '0;
                    oexp_d  = '0;
                    grs_d   = '0;
                    spc_d   = 1'b1;
                    sval_d  = sp_value;
                    inv_d   = sp_inv;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q
                              + ({24'd0, mcand_q} << cnt_q);
                    end
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == 5'(ITER - 1)) begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                mant_d  = m_n;
                oexp_d  = e_n[8:0];
                grs_d   = {m_n[23], m_n[22], |m_n[21:0]};
                spc_d   = 1'b0;
                sval_d  = '0;
                inv_d   = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                if (e_n >= 10'sd255) begin
                    spc_d  = 1'b1;
                    ovf_d  = 1'b1;
                    sval_d = ovf_value(sign, rm_q);
                end else if (e_n <= 10'sd0) begin
                    spc_d  = 1'b1;
                    unf_d  = 1'b1;
                    sval_d = {sign, 31'd0};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rm_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            mant_q   <= '0;
            oexp_q   <= '0;
            grs_q    <= '0;
            spc_q    <= 1'b0;
            sval_q   <= '0;
            inv_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rm_q     <= rm_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            oexp_q   <= oexp_d;
            grs_q    <= grs_d;
            spc_q    <= spc_d;
            sval_q   <= sval_d;
            inv_q    <= inv_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign in_ready          = (state_q == IDLE);
    assign out_valid         = (state_q == DONE);
    assign out_mantissa      = mant_q;
    assign out_exponent      = oexp_q;
    assign out_sign          = sign;
    assign out_guard         = grs_q[2];
    assign out_round         = grs_q[1];
    assign out_sticky        = grs_q[0];
    assign out_rm            = rm_q;
    assign out_special       = spc_q;
    assign out_special_value = sval_q;
    assign out_invalid       = inv_q;
    assign out_overflow      = ovf_q;
    assign out_underflow     = unf_q;

endmodule
